palette_lookup_arbiter: RTL

//  Shares one combinational sprite palette (4-bit index -> 12-bit RGB) between

---
 rtl/palette_lookup_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shares one combinational sprite palette (index -> packed RGB) between
//   NUM_REQ sprite renderers. A round-robin arbiter grants one requester per
//   clock and drives its index to the palette. The returned colour is
//   registered and handed back to the winner one clock later.
//
//   Optional feature: define PALETTE_FLASH_EN to add the hit-flash
//   (flash_trig port, flash counter, FLASH_IDX recolour to all ones).
module palette_lookup_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int IDX_W        = 4,
  parameter int RGB_W        = 12,
  parameter int FLASH_CYCLES = 1024,
  parameter int FLASH_IDX    = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [RGB_W-1:0]         pal_rgb,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [RGB_W-1:0]         rsp_rgb
`ifdef PALETTE_FLASH_EN
  ,
  input  logic                     flash_trig
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer holds the last winner; search starts one past it.
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [RGB_W-1:0]   rsp_rgb_q, rsp_rgb_d;

  logic [IDX_W-1:0]   idx_arr [NUM_REQ];
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   slot;
  logic [RGB_W-1:0]   lookup_rgb;

  // Requester slot visited k steps after the pointer, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] p, input int k);
    int c;
    c = int'(p) + k;
    if (c >= NUM_REQ) c = c - NUM_REQ;
    return PTR_W'(c);
  endfunction

  // Unpack the per-requester palette indices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_arr[i] = req_index[i*IDX_W +: IDX_W];
    end
  end

  // Round-robin search from ptr+1; first asserted request wins the palette.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    slot      = '0;
    gnt       = '0;
    pal_index = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      slot = rr_slot(ptr_q, k);
      if (!found && req[slot]) begin
        found = 1'b1;
        win   = slot;
      end
    end
    if (found) begin
      gnt[win]  = 1'b1;
      pal_index = idx_arr[win];
    end
  end

`ifdef PALETTE_FLASH_EN
  localparam int CNT_W = $clog2(FLASH_CYCLES + 1);

  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic             flash_active;

  // During a flash the chosen index is recoloured to full white.
  function automatic logic [RGB_W-1:0] flash_rgb(input logic [IDX_W-1:0] idx,
                                                 input logic [RGB_W-1:0] rgb,
                                                 input logic             active);
    if (active && (idx == IDX_W'(FLASH_IDX))) return '1;
    return rgb;
  endfunction

  assign flash_active = (flash_cnt_q != '0);

  // A trigger reloads the counter (winning over the decrement); else count down to zero.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_trig) begin
      flash_cnt_d = CNT_W'(FLASH_CYCLES);
    end else if (flash_active) begin
      flash_cnt_d = flash_cnt_q - CNT_W'(1);
    end
  end

  // Flash counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign lookup_rgb = flash_rgb(pal_index, pal_rgb, flash_active);
`else
  logic [1:0] unused_flash_cfg;
  assign unused_flash_cfg = {FLASH_CYCLES[0], FLASH_IDX[0]};
  assign lookup_rgb       = pal_rgb;
`endif

  // Next state: response mirrors this cycle's grant; colour and pointer move only on a grant.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = gnt;
    rsp_rgb_d   = rsp_rgb_q;
    if (found) begin
      ptr_d     = win;
      rsp_rgb_d = lookup_rgb;
    end
  end

  // Pointer and response registers; reset gives requester 0 first priority.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      rsp_valid_q <= '0;
      rsp_rgb_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rgb_q   <= rsp_rgb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rgb   = rsp_rgb_q;

endmodule
